// File: rtl/traffic_pkg.sv
// Shared phase encodings and lamp decode for the intersection phase scheduler.
package traffic_pkg;

   typedef enum logic [2:0] {
      PH_NS_G = 3'd0,
      PH_NS_Y = 3'd1,
      PH_AR_A = 3'd2,
      PH_EW_G = 3'd3,
      PH_EW_Y = 3'd4,
      PH_AR_B = 3'd5
   } phase_t;

   typedef struct packed {
      logic ns_red;
      logic ns_yellow;
      logic ns_green;
      logic ew_red;
      logic ew_yellow;
      logic ew_green;
   } lamps_t;

   // Any phase that lights nothing explicitly, including corrupt codes, shows all-red.
   function automatic lamps_t lamp_decode(input phase_t p);
      lamps_t l;
      l = 6'b100100;
      case (p)
         PH_NS_G: begin
            l.ns_red   = 1'b0;
            l.ns_green = 1'b1;
         end
         PH_NS_Y: begin
            l.ns_red    = 1'b0;
            l.ns_yellow = 1'b1;
         end
         PH_EW_G: begin
            l.ew_red   = 1'b0;
            l.ew_green = 1'b1;
         end
         PH_EW_Y: begin
            l.ew_red    = 1'b0;
            l.ew_yellow = 1'b1;
         end
         default: l = 6'b100100;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Request inputs and lamp/status outputs of the scheduler, bundled as one port.
interface intersection_phase_scheduler_if;

   logic       ew_req;
   logic       preempt;
   logic       ns_red;
   logic       ns_yellow;
   logic       ns_green;
   logic       ew_red;
   logic       ew_yellow;
   logic       ew_green;
   logic       ew_pending;
   logic [2:0] phase;

   modport master (
      input  ew_req, preempt,
      output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ew_pending, phase
   );

   modport slave (
      output ew_req, preempt,
      input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ew_pending, phase
   );

endinterface

// File: rtl/phase_timer.sv
// Phase duration counter: loads on phase entry, counts down and holds at zero.
module phase_timer #(
   parameter int CNT_W   = 6,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Holding at zero lets a resting phase wait indefinitely without wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= CNT_W'(RST_VAL);
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach signal sequencer: NS rests green, EW served on latched request,
// yellow and all-red between greens, emergency preempt forces NS green.
module intersection_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int NS_GREEN_TIME = 20,
   parameter int EW_GREEN_TIME = 15,
   parameter int YELLOW_TIME   = 5,
   parameter int ALL_RED_TIME  = 2,
   parameter int CNT_W         = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   intersection_phase_scheduler_if.master bus
);

   localparam logic [CNT_W-1:0] NS_LOAD = CNT_W'(NS_GREEN_TIME - 1);
   localparam logic [CNT_W-1:0] EW_LOAD = CNT_W'(EW_GREEN_TIME - 1);
   localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALL_RED_TIME - 1);

   phase_t           phase_cur;
   phase_t           phase_next;
   lamps_t           lamps;
   logic             pending;
   logic             timer_zero;
   logic             timer_load;
   logic [CNT_W-1:0] timer_load_val;
   logic             req_accepted;
   logic             enter_ew;

   function automatic logic [CNT_W-1:0] load_for(input phase_t p);
      case (p)
         PH_NS_G: return NS_LOAD;
         PH_EW_G: return EW_LOAD;
         PH_NS_Y: return Y_LOAD;
         PH_EW_Y: return Y_LOAD;
         default: return AR_LOAD;
      endcase
   endfunction

   // A phase change always reloads the timer with the new phase's duration.
   always_comb begin
      phase_next = phase_cur;
      case (phase_cur)
         PH_NS_G: if (timer_zero && (pending || bus.ew_req) && !bus.preempt) phase_next = PH_NS_Y;
         PH_NS_Y: if (timer_zero) phase_next = PH_AR_A;
         PH_AR_A: if (timer_zero) phase_next = bus.preempt ? PH_NS_G : PH_EW_G;
         PH_EW_G: if (timer_zero || bus.preempt) phase_next = PH_EW_Y;
         PH_EW_Y: if (timer_zero) phase_next = PH_AR_B;
         PH_AR_B: if (timer_zero) phase_next = PH_NS_G;
         default: phase_next = PH_AR_B;
      endcase
   end

   assign timer_load     = (phase_next != phase_cur);
   assign timer_load_val = load_for(phase_next);
   assign req_accepted   = bus.ew_req && (phase_cur inside {PH_NS_G, PH_NS_Y, PH_AR_A, PH_AR_B});
   assign enter_ew       = (phase_next == PH_EW_G) && (phase_cur != PH_EW_G);

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALL_RED_TIME - 1)
   ) timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_load_val),
      .zero     (timer_zero)
   );

   // Lamps are decoded from the next phase so they update on the same edge as the phase register.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_cur <= PH_AR_B;
         lamps     <= lamp_decode(PH_AR_B);
         pending   <= 1'b0;
      end else begin
         phase_cur <= phase_next;
         lamps     <= lamp_decode(phase_next);
         if (enter_ew) begin
            pending <= 1'b0;
         end else if (req_accepted) begin
            pending <= 1'b1;
         end
      end
   end

   assign bus.ns_red     = lamps.ns_red;
   assign bus.ns_yellow  = lamps.ns_yellow;
   assign bus.ns_green   = lamps.ns_green;
   assign bus.ew_red     = lamps.ew_red;
   assign bus.ew_yellow  = lamps.ew_yellow;
   assign bus.ew_green   = lamps.ew_green;
   assign bus.ew_pending = pending;
   assign bus.phase      = phase_cur;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with an age-based phase model.
module tb_intersection_phase_scheduler;
   import traffic_pkg::*;

   localparam int NS_T = 4;
   localparam int EW_T = 3;
   localparam int Y_T  = 2;
   localparam int AR_T = 1;

   localparam int M_NS_G = 0;
   localparam int M_NS_Y = 1;
   localparam int M_AR_A = 2;
   localparam int M_EW_G = 3;
   localparam int M_EW_Y = 4;
   localparam int M_AR_B = 5;

   localparam logic [5:0] LAMPS_ALL_RED  = 6'b100_100;
   localparam logic [5:0] LAMPS_NS_GREEN = 6'b001_100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   intersection_phase_scheduler_if bus ();

   intersection_phase_scheduler #(
      .NS_GREEN_TIME (NS_T),
      .EW_GREEN_TIME (EW_T),
      .YELLOW_TIME   (Y_T),
      .ALL_RED_TIME  (AR_T),
      .CNT_W         (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: phase index in ring order plus the number of cycles spent in it so far.
   int m_ph;
   int m_age;
   bit m_pend;
   bit m_valid = 1'b0;

   function automatic int phase_len(input int p);
      case (p)
         M_NS_G:          return NS_T;
         M_EW_G:          return EW_T;
         M_NS_Y, M_EW_Y:  return Y_T;
         default:         return AR_T;
      endcase
   endfunction

   function automatic logic [2:0] phase_code(input int p);
      case (p)
         M_NS_G:  return PH_NS_G;
         M_NS_Y:  return PH_NS_Y;
         M_AR_A:  return PH_AR_A;
         M_EW_G:  return PH_EW_G;
         M_EW_Y:  return PH_EW_Y;
         default: return PH_AR_B;
      endcase
   endfunction

   function automatic logic [5:0] phase_lamps(input int p);
      logic ns_g, ns_y, ew_g, ew_y;
      ns_g = (p == M_NS_G);
      ns_y = (p == M_NS_Y);
      ew_g = (p == M_EW_G);
      ew_y = (p == M_EW_Y);
      return {!(ns_g || ns_y), ns_y, ns_g, !(ew_g || ew_y), ew_y, ew_g};
   endfunction

   task automatic model_step();
      int  nx;
      bit  req;
      bit  pre;
      req = (bus.ew_req === 1'b1);
      pre = (bus.preempt === 1'b1);
      if (rst) begin
         m_ph    = M_AR_B;
         m_age   = 1;
         m_pend  = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         nx = m_ph;
         case (m_ph)
            M_NS_G:  if (m_age >= NS_T && (m_pend || req) && !pre) nx = M_NS_Y;
            M_EW_G:  if (pre || m_age >= EW_T) nx = M_EW_Y;
            M_AR_A:  if (m_age >= AR_T) nx = pre ? M_NS_G : M_EW_G;
            default: if (m_age >= phase_len(m_ph)) nx = (m_ph + 1) % 6;
         endcase
         if (nx == M_EW_G && m_ph != M_EW_G) m_pend = 1'b0;
         else if (req && (m_ph inside {M_NS_G, M_NS_Y, M_AR_A, M_AR_B})) m_pend = 1'b1;
         m_age = (nx == m_ph) ? m_age + 1 : 1;
         m_ph  = nx;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check_output("model_phase", {5'b0, bus.phase}, {5'b0, phase_code(m_ph)});
         check_output("model_lamps",
                      {2'b0, bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green},
                      {2'b0, phase_lamps(m_ph)});
         check_output("model_ew_pending", {7'b0, bus.ew_pending}, {7'b0, m_pend});
      end
   end

   task automatic apply_stimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_phase(input string name, input logic [2:0] expected);
      check_output(name, {5'b0, bus.phase}, {5'b0, expected});
   endtask

   task automatic check_lamps(input string name, input logic [5:0] expected);
      check_output(name,
                   {2'b0, bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green},
                   {2'b0, expected});
   endtask

   task automatic check_pending(input string name, input logic expected);
      check_output(name, {7'b0, bus.ew_pending}, {7'b0, expected});
   endtask

   logic [2:0] t2_seq [12];

   initial begin
      bus.ew_req  = 1'b0;
      bus.preempt = 1'b0;
      t2_seq = '{PH_NS_G, PH_NS_G, PH_NS_Y, PH_NS_Y, PH_AR_A, PH_EW_G,
                 PH_EW_G, PH_EW_G, PH_EW_Y, PH_EW_Y, PH_AR_B, PH_NS_G};

      // Reset with no request: one all-red cycle, then NS green rests.
      rst = 1'b1;
      apply_stimulus(2);
      rst = 1'b0;
      check_phase("t1_reset_phase", PH_AR_B);
      check_lamps("t1_reset_lamps", LAMPS_ALL_RED);
      check_pending("t1_reset_pending", 1'b0);
      apply_stimulus(1);
      check_lamps("t1_first_ns_green", LAMPS_NS_GREEN);
      apply_stimulus(50);
      check_lamps("t1_ns_green_rest", LAMPS_NS_GREEN);
      check_pending("t1_pending_idle", 1'b0);

      // Single-cycle request in the first NS green cycle walks the whole ring once.
      rst = 1'b1;
      apply_stimulus(1);
      rst = 1'b0;
      apply_stimulus(1);
      bus.ew_req = 1'b1;
      apply_stimulus(1);
      bus.ew_req = 1'b0;
      check_pending("t2_latched", 1'b1);
      check_phase("t2_ns_green_a2", PH_NS_G);
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(1);
         check_phase($sformatf("t2_seq%0d", i), t2_seq[i]);
         if (i == 4) check_pending("t2_pending_in_ar_a", 1'b1);
         if (i == 5) check_pending("t2_cleared_on_ew_g", 1'b0);
      end
      apply_stimulus(10);
      check_phase("t2_ns_rest", PH_NS_G);

      // Held request repeats the ring with period 13.
      bus.ew_req = 1'b1;
      apply_stimulus(1);
      check_phase("t3_ns_y_start", PH_NS_Y);
      apply_stimulus(13);
      check_phase("t3_period_1", PH_NS_Y);
      apply_stimulus(13);
      check_phase("t3_period_2", PH_NS_Y);
      bus.ew_req = 1'b0;
      apply_stimulus(20);
      check_phase("t3_back_to_rest", PH_NS_G);
      check_pending("t3_pending_idle", 1'b0);

      // Preempt in the first EW green cycle truncates it.
      bus.ew_req = 1'b1;
      apply_stimulus(1);
      bus.ew_req = 1'b0;
      apply_stimulus(3);
      check_phase("t4_ew_g_1", PH_EW_G);
      bus.preempt = 1'b1;
      apply_stimulus(1);
      check_phase("t4_ew_y_1", PH_EW_Y);
      apply_stimulus(1);
      check_phase("t4_ew_y_2", PH_EW_Y);
      apply_stimulus(1);
      check_phase("t4_ar_b", PH_AR_B);
      apply_stimulus(1);
      check_phase("t4_ns_g", PH_NS_G);
      bus.ew_req = 1'b1;
      apply_stimulus(1);
      bus.ew_req = 1'b0;
      apply_stimulus(10);
      check_phase("t4_ns_held", PH_NS_G);
      check_pending("t4_pending_during_preempt", 1'b1);

      // Preempt during AR_A redirects to NS green and keeps the request.
      bus.preempt = 1'b0;
      apply_stimulus(3);
      check_phase("t5_ar_a", PH_AR_A);
      bus.preempt = 1'b1;
      apply_stimulus(1);
      check_phase("t5_redirect_ns_g", PH_NS_G);
      check_pending("t5_pending_kept", 1'b1);
      bus.preempt = 1'b0;
      apply_stimulus(3);
      check_phase("t5_ns_g_a4", PH_NS_G);
      apply_stimulus(1);
      check_phase("t5_ns_y", PH_NS_Y);
      apply_stimulus(3);
      check_phase("t5_ew_served", PH_EW_G);
      check_pending("t5_pending_cleared", 1'b0);

      // Reset in the middle of EW green, then in NS green with a latched request.
      apply_stimulus(1);
      rst = 1'b1;
      apply_stimulus(1);
      rst = 1'b0;
      check_phase("t6_reset_phase", PH_AR_B);
      check_lamps("t6_reset_lamps", LAMPS_ALL_RED);
      check_pending("t6_reset_pending", 1'b0);
      apply_stimulus(1);
      check_phase("t6_ns_g", PH_NS_G);
      bus.ew_req = 1'b1;
      apply_stimulus(1);
      bus.ew_req = 1'b0;
      check_pending("t6_latched", 1'b1);
      rst = 1'b1;
      apply_stimulus(1);
      rst = 1'b0;
      check_pending("t6_reset_clears_pending", 1'b0);
      check_phase("t6_reset_phase_2", PH_AR_B);
      apply_stimulus(5);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
